fast_inv_sqrt_nr: RTL and testbench
===================================

Name: fast_inv_sqrt_nr

Overview:
Parametrised successor to the single-shot fast inverse square root block. It computes y ≈ 1/sqrt(x) for an unsigned fixed-point input: fixed-to-single conversion, the magic-constant bit hack, single-to-fixed conversion, then a configurable number of Newton-Raphson refinement iterations. Word width, iteration count and magic constant are parameters. Sits behind a valid/ready stream on the SweRVolf peripheral path and adds a saturation status flag.

Parameters:
INT_WIDTH, 12, integer bits of the unsigned Q(INT.FRACT) input and output format
FRACT_WIDTH, 4, fractional bits; must be >= 1; W = INT_WIDTH+FRACT_WIDTH, W <= 24
NR_ITERS, 1, number of Newton-Raphson iterations, 0..3
MAGIC, 32'h5f3759df, bit-hack constant

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_data  in  W  operand x, unsigned Q(INT.FRACT)
in_valid  in  1  operand valid
in_ready  out  1  block can accept an operand
out_data  out  W  result y, unsigned Q(INT.FRACT)
out_sat  out  1  result was clamped: zero input, range overflow, or negative correction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; out_valid=0, out_data=0, out_sat=0, in_ready=0 while rst is high; iteration counter and internal registers cleared; any in-flight operand discarded.
- in_ready = (state==IDLE) && !rst. Accept on the edge where in_valid && in_ready; register x and x_half = x>>1 (logical shift).
- States: IDLE -> HACK -> TOFIX -> (NR_SQ -> NR_UPD) x NR_ITERS -> DONE -> IDLE.
- HACK: s = fixToSingle(x), exact for W<=24; y0s <= MAGIC - (s>>1) (32-bit unsigned subtract). If x==0, set the sticky sat flag and force the final result to all-ones.
- TOFIX: y <= singleToFix(y0s), truncated toward zero; magnitude >= 2^INT_WIDTH saturates to 2^W-1 and sets sat; magnitude < 2^-FRACT_WIDTH gives 0.
- NR_SQ: p <= (x_half*y*y) >> 2*FRACT_WIDTH. Full-precision product, FRACT_WIDTH fraction bits, p width 2W.
- NR_UPD: d = (3<<(FRACT_WIDTH-1)) - p, signed. If d<0, y<=0 and sat set. Otherwise y <= (y*d)>>FRACT_WIDTH, saturated to 2^W-1 with sat set on overflow. Increment the iteration counter. After the NR_ITERS-th update, go to DONE.
- NR_ITERS=0 goes TOFIX -> DONE.
- Latency: out_valid rises exactly L = 3+2*NR_ITERS rising edges after the accepting edge. out_data and out_sat update on that same edge.
- DONE: out_valid=1; out_data and out_sat held stable while out_ready=0.
- Output handshake on the edge with out_valid && out_ready: out_valid<=0, state<=IDLE. out_data and out_sat keep their last values.
- No overlap: a new operand is accepted no earlier than the edge after the output handshake, so the minimum issue period is L+2 cycles.
- in_valid is ignored outside IDLE. in_data only needs to be stable on the accepting edge.
- out_sat is sticky per operation and cleared on accept.

Test Plan:
1. Defaults, NR_ITERS=0, in_data=16'h0001 (0.0625) -> y0s=32'h407759DF, out_data=16'h003D, out_sat=0, out_valid exactly 3 edges after accept.
2. NR_ITERS=1, in_data=16'h0040 (4.0) -> y0=16'h0007; NR gives p=6, d=18, out_data=16'h0007, out_sat=0, latency 5 edges.
3. in_data=16'h0000 -> out_data=16'hFFFF, out_sat=1. The next operand 16'h0040 returns out_sat=0.
4. NR_ITERS=2: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_data, out_sat stable and in_ready=0 throughout; latency 7 edges; back-to-back issue period 9 cycles.
5. Assert rst asynchronously during NR_SQ -> out_valid=0 and in_ready=0 immediately. After release: state IDLE, in_ready=1, the dropped operand never appears, and the next operand yields the correct result.
6. in_valid pulsed while the block is busy -> the operand is ignored, and exactly one result per accepted handshake is produced (scoreboard against a double-precision model within a ±1 LSB tolerance).

Source files
------------

// File: rtl/fast_inv_sqrt_nr.sv
// fast_inv_sqrt_nr: y ~= 1/sqrt(x) on unsigned Q(INT_WIDTH.FRACT_WIDTH) data.
// The estimate comes from the float bit hack, followed by NR_ITERS Newton-Raphson steps.
// Latency is 3 + 2*NR_ITERS edges from accept to out_valid.
// Operations never overlap: in_ready is low from accept until the result is handshaken.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   in_data/valid/ready  operand stream, unsigned fixed point
//   out_data/valid/ready result stream; out_data holds until out_ready
//   out_sat            result was clamped (zero input, range overflow, negative correction)
module fast_inv_sqrt_nr #(
    parameter int          INT_WIDTH   = 12,
    parameter int          FRACT_WIDTH = 4,
    parameter int          NR_ITERS    = 1,
    parameter logic [31:0] MAGIC       = 32'h5f3759df
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]   in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]   out_data,
    output logic                               out_sat,
    output logic                               out_valid,
    input  logic                               out_ready
);
    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int P2 = 2 * W;
    localparam int P3 = 3 * W;
    localparam int LAST_ITER = (NR_ITERS > 0) ? NR_ITERS - 1 : 0;
    // 1.5 in the product's fixed-point format
    localparam logic [P2-1:0] THREE_HALVES = P2'(32'd3 << (FRACT_WIDTH - 1));

    typedef enum logic [2:0] {IDLE, HACK, TOFIX, NR_SQ, NR_UPD, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    x_r;
    logic [W-1:0]    x_half;
    logic [30:0]     y0_mag;   // the estimate's sign bit is never used, only its magnitude
    logic [W-1:0]    y_r;
    logic [P2-1:0]   p_r;
    logic [1:0]      iter;
    logic            sat_r;
    logic            zero_r;

    // Exact conversion: W <= 24 means every input fits in the 24-bit significand.
    function automatic logic [31:0] fix_to_single(input logic [W-1:0] v);
        int          msb;
        logic [31:0] r;
        msb = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) msb = i;
        end
        r = '0;
        if (v != '0) begin
            r = {1'b0, 8'(127 + msb - FRACT_WIDTH), 23'(24'(v) << (23 - msb))};
        end
        return r;
    endfunction

    // Returns {sat, value}. Values are truncated toward zero; anything at or above
    // 2^INT_WIDTH clamps. With W <= 24 the significand only ever shifts right.
    function automatic logic [W:0] single_to_fix(input logic [30:0] f);
        int          e;
        int          rs;
        logic [23:0] m;
        logic [W:0]  r;
        e  = int'(f[30:23]) - 127;
        m  = {1'b1, f[22:0]};
        rs = 23 - e - FRACT_WIDTH;
        if (f[30:23] == 8'd0) begin
            r = '0;
        end else if (e >= INT_WIDTH) begin
            r = {1'b1, {W{1'b1}}};
        end else begin
            r = {1'b0, W'(m >> rs)};
        end
        return r;
    endfunction

    logic [W:0]          tofix;
    logic [P3-1:0]       sq_full;
    logic [P3-1:0]       sq_shift;
    logic [P2-1:0]       p_next;
    logic signed [P2+1:0] d;
    logic                d_neg;
    logic [P3-1:0]       upd_full;
    logic [P3-1:0]       upd_shift;
    logic                upd_ovf;
    logic [W-1:0]        y_upd;

    always_comb begin
        tofix    = single_to_fix(y0_mag);
        sq_full  = P3'(x_half) * P3'(y_r) * P3'(y_r);
        sq_shift = sq_full >> (2 * FRACT_WIDTH);
        // Clamping p (rather than dropping high bits) keeps a huge product negative in d.
        p_next   = (|sq_shift[P3-1:P2]) ? '1 : sq_shift[P2-1:0];
        d        = $signed({2'b00, THREE_HALVES}) - $signed({2'b00, p_r});
        d_neg    = d[P2+1];
        upd_full = P3'(y_r) * P3'($unsigned(d));
        upd_shift = upd_full >> FRACT_WIDTH;
        upd_ovf  = |upd_shift[P3-1:W];
        y_upd    = upd_ovf ? '1 : upd_shift[W-1:0];
    end

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = HACK;
            HACK:   state_nxt = TOFIX;
            TOFIX:  state_nxt = (NR_ITERS == 0) ? DONE : NR_SQ;
            NR_SQ:  state_nxt = NR_UPD;
            NR_UPD: state_nxt = (int'(iter) == LAST_ITER) ? DONE : NR_SQ;
            DONE:   if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r       <= '0;
            x_half    <= '0;
            y0_mag    <= '0;
            y_r       <= '0;
            p_r       <= '0;
            iter      <= '0;
            sat_r     <= 1'b0;
            zero_r    <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r    <= in_data;
                        x_half <= in_data >> 1;
                        iter   <= '0;
                        sat_r  <= 1'b0;
                        zero_r <= 1'b0;
                    end
                end
                HACK: begin
                    y0_mag <= 31'(MAGIC - (fix_to_single(x_r) >> 1));
                    // 1/sqrt(0) has no finite answer; report full scale at the end
                    if (x_r == '0) begin
                        sat_r  <= 1'b1;
                        zero_r <= 1'b1;
                    end
                end
                TOFIX: begin
                    y_r <= tofix[W-1:0];
                    if (tofix[W]) sat_r <= 1'b1;
                end
                NR_SQ: begin
                    p_r <= p_next;
                end
                NR_UPD: begin
                    if (d_neg) begin
                        y_r   <= '0;
                        sat_r <= 1'b1;
                    end else begin
                        y_r <= y_upd;
                        if (upd_ovf) sat_r <= 1'b1;
                    end
                    iter <= iter + 2'd1;
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for out_ready.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= zero_r ? '1 : y_r;
                        out_sat   <= sat_r;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fast_inv_sqrt_nr.sv
// Three instances (NR_ITERS = 0, 1, 2) share clock and reset; dut<k> has NR_ITERS = k.
// The driver pushes hand-computed expectations at accept; a negedge monitor checks them.
module tb_fast_inv_sqrt_nr;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data [3];
    logic [W-1:0] out_data [3];
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_sat;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int           inst;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic         sat;
        int           acc;
    } exp_t;
    exp_t sbq[$];

    fast_inv_sqrt_nr #(.NR_ITERS(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_sat(out_sat[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));
    fast_inv_sqrt_nr #(.NR_ITERS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_sat(out_sat[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));
    fast_inv_sqrt_nr #(.NR_ITERS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_sat(out_sat[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, want %0h", name, k, got, want);
        end
    endtask

    function automatic int find_entry(input int k);
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].inst == k) return i;
        end
        return -1;
    endfunction

    // Monitor: a result is new when valid was not already pending from the previous cycle.
    logic [2:0] prev_vld = '0;
    int         mon_idx;
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k]) begin
                    mon_idx = find_entry(k);
                    check("busy_in_ready", k, 32'(in_ready[k]), 32'd0);
                    if (mon_idx < 0) begin
                        if (!prev_vld[k]) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_result dut%0d: got out_data %0h, want no result", k, out_data[k]);
                        end
                    end else begin
                        if (!prev_vld[k]) check("latency", k, 32'(cyc - sbq[mon_idx].acc), 32'(3 + 2 * k));
                        check("out_data", k, 32'(out_data[k]), 32'(sbq[mon_idx].dout));
                        check("out_sat", k, 32'(out_sat[k]), 32'(sbq[mon_idx].sat));
                        if (out_ready[k]) sbq.delete(mon_idx);
                    end
                end
                prev_vld[k] = out_valid[k] & ~out_ready[k];
            end
        end
    end

    task automatic issue(input int k, input logic [W-1:0] d, input logic [W-1:0] e,
                         input logic s, output int acc);
        int n;
        n   = 0;
        acc = -1;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        while (acc < 0 && n < 100) begin
            @(negedge clk);
            if (in_ready[k]) begin
                acc = cyc + 1;
                sbq.push_back('{k, d, e, s, acc});
            end
            n++;
        end
        if (acc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept dut%0d: got no in_ready in 100 cycles, want accept", k);
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid[k] = 1'b0;
        in_data[k]  = 16'hA5A5;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100us, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, a2, n, idx;
        in_valid  = '0;
        out_ready = 3'b111;
        for (int k = 0; k < 3; k++) in_data[k] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
            check("rst_out_data", k, 32'(out_data[k]), 32'd0);
            check("rst_out_sat", k, 32'(out_sat[k]), 32'd0);
            check("rst_in_ready", k, 32'(in_ready[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("idle_in_ready", k, 32'(in_ready[k]), 32'd1);

        // NR_ITERS = 0: raw bit-hack estimate
        issue(0, 16'h0001, 16'h003D, 1'b0, a0);   // 0.0625 -> 3.8125
        issue(0, 16'h0040, 16'h0007, 1'b0, a0);   // 4.0    -> 0.4375
        issue(0, 16'h0010, 16'h000F, 1'b0, a0);   // 1.0    -> 0.9375
        issue(0, 16'h0002, 16'h002D, 1'b0, a0);   // 0.125  -> 2.8125
        issue(0, 16'h0000, 16'hFFFF, 1'b1, a0);   // zero clamps
        issue(0, 16'hFFFF, 16'h0000, 1'b0, a0);   // below one LSB -> 0
        drain();

        // NR_ITERS = 1
        issue(1, 16'h0040, 16'h0007, 1'b0, a0);   // p=6, d=18
        issue(1, 16'h0010, 16'h000F, 1'b0, a0);   // p=7, d=17
        issue(1, 16'h0100, 16'h0003, 1'b0, a0);   // 16.0: p=4, d=20
        issue(1, 16'h0004, 16'h001F, 1'b0, a0);   // 0.25: 30 -> 31
        issue(1, 16'h0002, 16'h002F, 1'b0, a0);   // 0.125: 45 -> 47
        issue(1, 16'h0090, 16'h0005, 1'b0, a0);   // 9.0: p=7
        issue(1, 16'h0000, 16'hFFFF, 1'b1, a0);
        issue(1, 16'h0040, 16'h0007, 1'b0, a0);   // sticky sat cleared by the new accept
        issue(1, 16'hFFFF, 16'h0000, 1'b0, a0);
        issue(1, 16'h0001, 16'h005B, 1'b0, a0);   // x_half=0: y*1.5
        drain();

        // Reset during NR_SQ: the in-flight operand must vanish
        issue(1, 16'h0010, 16'h000F, 1'b0, a0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 1, 32'(out_valid[1]), 32'd0);
        check("arst_out_data", 1, 32'(out_data[1]), 32'd0);
        check("arst_in_ready_busy", 1, 32'(in_ready[1]), 32'd0);
        check("arst_in_ready_idle", 0, 32'(in_ready[0]), 32'd0);
        idx = find_entry(1);
        if (idx >= 0) sbq.delete(idx);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 1, 32'(in_ready[1]), 32'd1);
        issue(1, 16'h0040, 16'h0007, 1'b0, a0);

        // in_valid pulsed while busy must be ignored
        issue(1, 16'h0010, 16'h000F, 1'b0, a0);
        in_valid[1] = 1'b1;
        in_data[1]  = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        drain();

        // NR_ITERS = 2: hold the result for 10 cycles
        out_ready[2] = 1'b0;
        issue(2, 16'h0004, 16'h0020, 1'b0, a0);   // 30 -> 31 -> 32
        n = 0;
        while (!out_valid[2] && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("hold_valid_seen", 2, 32'(out_valid[2]), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
        drain();

        // Back-to-back issue period is latency + 2
        issue(2, 16'h0010, 16'h000F, 1'b0, a0);
        issue(2, 16'h0100, 16'h0003, 1'b0, a1);
        issue(2, 16'h0001, 16'h0088, 1'b0, a2);   // 61 -> 91 -> 136
        check("period_1", 2, 32'(a1 - a0), 32'd9);
        check("period_2", 2, 32'(a2 - a1), 32'd9);
        issue(2, 16'h0040, 16'h0007, 1'b0, a0);
        issue(2, 16'h0000, 16'hFFFF, 1'b1, a0);
        drain();

        repeat (20) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
